jpeg_rle_symbolizer: RTL and testbench

//  Converts 8x8 blocks of quantized coefficients, in zigzag order, into JPEG baseline symbols.

---
 rtl/jpeg_rle_symbolizer.sv | 196 +++++++++++++++++++
 tb/tb_jpeg_rle_symbolizer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_rle_symbolizer.sv
// JPEG baseline run-length symbolizer: zigzag-ordered quantized coefficients in,
// (run, size, amplitude) symbols out, with differential DC, ZRL insertion and EOB.
module jpeg_rle_symbolizer #(
  parameter int unsigned COEF_W = 11,
  parameter int unsigned AMP_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sof,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_dc,
  output logic [3:0]        out_run,
  output logic [3:0]        out_size,
  output logic [AMP_W-1:0]  out_amp,
  output logic              out_last
);

  localparam logic [0:0] StAccept = 1'b0;
  localparam logic [0:0] StZrl    = 1'b1;

  function automatic logic [3:0] cat_f(input logic [AMP_W-1:0] x);
    logic [AMP_W-1:0] mag;
    cat_f = '0;
    mag   = x[AMP_W-1] ? (~x + 1'b1) : x;
    for (int i = 0; i < AMP_W; i++) begin
      if (mag[i]) cat_f = 4'(i + 1);
    end
  endfunction

  // Negative values are sent as the low size bits of x-1 (one's complement of |x|).
  function automatic logic [AMP_W-1:0] enc_f(input logic [AMP_W-1:0] x, input logic [3:0] sz);
    logic [AMP_W-1:0] mask;
    mask  = (AMP_W'(1) << sz) - AMP_W'(1);
    enc_f = x[AMP_W-1] ? ((x - AMP_W'(1)) & mask) : x;
  endfunction

  logic [0:0]        state_q, state_d;
  logic [5:0]        idx_q, idx_d, idx_eff;
  logic [5:0]        zrun_q, zrun_d, zrun_eff;
  logic [COEF_W-1:0] dc_pred_q, dc_pred_d, pred_eff;
  logic [3:0]        hold_size_q, hold_size_d;
  logic [AMP_W-1:0]  hold_amp_q, hold_amp_d;
  logic              hold_last_q, hold_last_d;
  logic              alive_q;
  logic              out_valid_d, out_dc_d, out_last_d;
  logic [3:0]        out_run_d, out_size_d;
  logic [AMP_W-1:0]  out_amp_d;

  logic              slot_free, accept;
  logic [AMP_W-1:0]  coef_ext, pred_ext, sel;
  logic [3:0]        sel_size;
  logic [AMP_W-1:0]  sel_amp;

  assign slot_free = !out_valid || out_ready;
  // alive_q keeps in_ready low through reset and the release edge.
  assign in_ready  = alive_q && (state_q == StAccept) && slot_free;
  assign accept    = in_valid && in_ready;

  // sof in the same cycle as an accept makes that beat the DC of a fresh block.
  assign idx_eff  = sof ? 6'd0 : idx_q;
  assign zrun_eff = sof ? 6'd0 : zrun_q;
  assign pred_eff = sof ? '0 : dc_pred_q;

  assign coef_ext = {{(AMP_W - COEF_W){in_coef[COEF_W-1]}}, in_coef};
  assign pred_ext = {{(AMP_W - COEF_W){pred_eff[COEF_W-1]}}, pred_eff};
  assign sel      = (idx_eff == 6'd0) ? (coef_ext - pred_ext) : coef_ext;
  assign sel_size = cat_f(sel);
  assign sel_amp  = enc_f(sel, sel_size);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    zrun_d      = zrun_q;
    dc_pred_d   = dc_pred_q;
    hold_size_d = hold_size_q;
    hold_amp_d  = hold_amp_q;
    hold_last_d = hold_last_q;
    out_valid_d = out_valid && !out_ready;
    out_dc_d    = out_dc;
    out_run_d   = out_run;
    out_size_d  = out_size;
    out_amp_d   = out_amp;
    out_last_d  = out_last;

    case (state_q)
      StAccept: begin
        if (accept) begin
          idx_d = idx_eff + 6'd1;
          if (idx_eff == 6'd0) begin
            out_valid_d = 1'b1;
            out_dc_d    = 1'b1;
            out_run_d   = 4'd0;
            out_size_d  = sel_size;
            out_amp_d   = sel_amp;
            out_last_d  = 1'b0;
            dc_pred_d   = in_coef;
            zrun_d      = 6'd0;
          end else if (in_coef == '0) begin
            if (idx_eff == 6'd63) begin
              out_valid_d = 1'b1;
              out_dc_d    = 1'b0;
              out_run_d   = 4'd0;
              out_size_d  = 4'd0;
              out_amp_d   = '0;
              out_last_d  = 1'b1;
              zrun_d      = 6'd0;
            end else begin
              zrun_d = zrun_eff + 6'd1;
            end
          end else if (zrun_eff < 6'd16) begin
            out_valid_d = 1'b1;
            out_dc_d    = 1'b0;
            out_run_d   = zrun_eff[3:0];
            out_size_d  = sel_size;
            out_amp_d   = sel_amp;
            out_last_d  = (idx_eff == 6'd63);
            zrun_d      = 6'd0;
          end else begin
            hold_size_d = sel_size;
            hold_amp_d  = sel_amp;
            hold_last_d = (idx_eff == 6'd63);
            zrun_d      = zrun_eff;
            state_d     = StZrl;
          end
        end
      end
      default: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_dc_d    = 1'b0;
          if (zrun_q >= 6'd16) begin
            out_run_d  = 4'd15;
            out_size_d = 4'd0;
            out_amp_d  = '0;
            out_last_d = 1'b0;
            zrun_d     = zrun_q - 6'd16;
          end else begin
            out_run_d  = zrun_q[3:0];
            out_size_d = hold_size_q;
            out_amp_d  = hold_amp_q;
            out_last_d = hold_last_q;
            zrun_d     = 6'd0;
            state_d    = StAccept;
          end
        end
      end
    endcase

    if (sof && !accept) begin
      state_d     = StAccept;
      idx_d       = 6'd0;
      zrun_d      = 6'd0;
      dc_pred_d   = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccept;
      idx_q       <= 6'd0;
      zrun_q      <= 6'd0;
      dc_pred_q   <= '0;
      hold_size_q <= 4'd0;
      hold_amp_q  <= '0;
      hold_last_q <= 1'b0;
      alive_q     <= 1'b0;
      out_valid   <= 1'b0;
      out_dc      <= 1'b0;
      out_run     <= 4'd0;
      out_size    <= 4'd0;
      out_amp     <= '0;
      out_last    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      zrun_q      <= zrun_d;
      dc_pred_q   <= dc_pred_d;
      hold_size_q <= hold_size_d;
      hold_amp_q  <= hold_amp_d;
      hold_last_q <= hold_last_d;
      alive_q     <= 1'b1;
      out_valid   <= out_valid_d;
      out_dc      <= out_dc_d;
      out_run     <= out_run_d;
      out_size    <= out_size_d;
      out_amp     <= out_amp_d;
      out_last    <= out_last_d;
    end
  end

endmodule

// File: tb/tb_jpeg_rle_symbolizer.sv
// Directed bench for jpeg_rle_symbolizer: whole blocks in, captured symbol lists compared
// against hand-computed expectations.
module tb_jpeg_rle_symbolizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sof;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_coef;
  logic        out_valid;
  logic        out_ready;
  logic        out_dc;
  logic [3:0]  out_run;
  logic [3:0]  out_size;
  logic [11:0] out_amp;
  logic        out_last;

  int total = 0;
  int bad   = 0;
  int zrl_viol = 0;
  logic [21:0] got[$];
  logic [21:0] exp[$];

  always #5 clk = ~clk;

  jpeg_rle_symbolizer #(.COEF_W(11), .AMP_W(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sof      (sof),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_coef  (in_coef),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_dc   (out_dc),
    .out_run  (out_run),
    .out_size (out_size),
    .out_amp  (out_amp),
    .out_last (out_last)
  );

  // Symbol packing: {dc, run, size, amp, last}
  function automatic logic [21:0] mk(input bit dc, input int run, input int sz, input int amp,
                                     input bit last);
    return {dc, 4'(run), 4'(sz), 12'(amp), last};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      got.push_back({out_dc, out_run, out_size, out_amp, out_last});
    if (rst_n && out_valid && !out_dc && out_run == 4'd15 && out_size == 4'd0 && in_ready)
      zrl_viol++;
  end

  task automatic send(input int c, input bit s);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_coef  = 11'(c);
    sof      = s;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sof      = 1'b0;
  endtask

  task automatic send_block(input int dc, input int pos, input int val, input bit s);
    send(dc, s);
    for (int i = 1; i < 64; i++) send((i == pos) ? val : 0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sof = 1'b0; in_valid = 1'b0; in_coef = '0; out_ready = 1'b1;
    #12;
    total++;
    if ({in_ready, out_valid, out_dc, out_run, out_size, out_amp, out_last} !== 24'd0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%0b v=%0b amp=%h, required all 0",
               in_ready, out_valid, out_amp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_ready: got %0b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_release: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_dc_eob;
    got.delete();
    send_block(100, 0, 0, 1'b1);
    exp = '{mk(1, 0, 7, 100, 0), mk(0, 0, 0, 0, 1)};
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("FAIL dc_eob_count: got %0d required %0d", got.size(), exp.size());
    end else foreach (exp[i]) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL dc_eob sym%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_dc_negdiff;
    got.delete();
    send_block(90, 0, 0, 1'b0);
    exp = '{mk(1, 0, 4, 5, 0), mk(0, 0, 0, 0, 1)};
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("FAIL dc_negdiff_count: got %0d required %0d", got.size(), exp.size());
    end else foreach (exp[i]) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL dc_negdiff sym%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_one_zrl;
    got.delete();
    send_block(0, 21, 3, 1'b0);
    exp = '{mk(1, 0, 7, 37, 0), mk(0, 15, 0, 0, 0), mk(0, 4, 2, 3, 0), mk(0, 0, 0, 0, 1)};
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("FAIL one_zrl_count: got %0d required %0d", got.size(), exp.size());
    end else foreach (exp[i]) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL one_zrl sym%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_three_zrl;
    got.delete();
    zrl_viol = 0;
    send_block(0, 63, -1, 1'b0);
    exp = '{mk(1, 0, 0, 0, 0), mk(0, 15, 0, 0, 0), mk(0, 15, 0, 0, 0), mk(0, 15, 0, 0, 0),
            mk(0, 14, 1, 0, 1)};
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("FAIL three_zrl_count: got %0d required %0d", got.size(), exp.size());
    end else foreach (exp[i]) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL three_zrl sym%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
    total++;
    if (zrl_viol !== 0) begin
      bad++;
      $display("FAIL zrl_ready_low: got %0d ready cycles during ZRL, required 0", zrl_viol);
    end
  endtask

  task automatic test_backpressure;
    logic [22:0] snap;
    got.delete();
    out_ready = 1'b0;
    send(7, 1'b0);
    snap = {out_valid, out_dc, out_run, out_size, out_amp, out_last};
    total++;
    if (snap !== {1'b1, mk(1, 0, 3, 7, 0)}) begin
      bad++;
      $display("FAIL stall_first: got %h required %h", snap, {1'b1, mk(1, 0, 3, 7, 0)});
    end
    in_valid = 1'b1;
    in_coef  = 11'd3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_dc, out_run, out_size, out_amp, out_last} !== snap || in_ready !== 1'b0)
      begin
        bad++;
        $display("FAIL stall_hold c%0d: got %h rdy=%0b required %h rdy=0", c,
                 {out_valid, out_dc, out_run, out_size, out_amp, out_last}, in_ready, snap);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3, 1'b0);
    send(-2, 1'b0);
    for (int i = 3; i < 64; i++) send(0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    exp = '{mk(1, 0, 3, 7, 0), mk(0, 0, 2, 3, 0), mk(0, 0, 2, 1, 0), mk(0, 0, 0, 0, 1)};
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("FAIL stall_count: got %0d required %0d", got.size(), exp.size());
    end else foreach (exp[i]) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL stall_order sym%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_sof_abort;
    got.delete();
    send(50, 1'b0);
    for (int i = 1; i < 9; i++) send(0, 1'b0);
    send(5, 1'b0);
    for (int i = 10; i < 30; i++) send(0, 1'b0);
    send_block(-5, 0, 0, 1'b1);
    exp = '{mk(1, 0, 6, 43, 0), mk(0, 8, 3, 5, 0), mk(1, 0, 3, 2, 0), mk(0, 0, 0, 0, 1)};
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("FAIL sof_count: got %0d required %0d", got.size(), exp.size());
    end else foreach (exp[i]) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL sof_abort sym%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_zrl;
    send(0, 1'b0);
    for (int i = 1; i < 63; i++) send(0, 1'b0);
    send(-1, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || out_run !== 4'd15 || out_size !== 4'd0) begin
      bad++;
      $display("FAIL zrl_before_reset: got v=%0b run=%0d size=%0d required v=1 run=15 size=0",
               out_valid, out_run, out_size);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_dc, out_run, out_size, out_amp, out_last} !== 24'd0) begin
      bad++;
      $display("FAIL async_reset: got rdy=%0b v=%0b run=%0d required all 0",
               in_ready, out_valid, out_run);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got.delete();
    send_block(3, 0, 0, 1'b0);
    exp = '{mk(1, 0, 2, 3, 0), mk(0, 0, 0, 0, 1)};
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("FAIL post_reset_count: got %0d required %0d", got.size(), exp.size());
    end else foreach (exp[i]) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL post_reset sym%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dc_eob();
    test_dc_negdiff();
    test_one_zrl();
    test_three_zrl();
    test_backpressure();
    test_sof_abort();
    test_reset_mid_zrl();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
